// File: rtl/key_step_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_step_conditioner_pkg                                     |
// | Description : Shared FSM state encoding and default 50 MHz timing          |
// |               constants for the pushbutton step conditioner.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package key_step_conditioner_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t PRESS_DB   = 3'd1;
  localparam state_t HELD       = 3'd2;
  localparam state_t REPEAT     = 3'd3;
  localparam state_t RELEASE_DB = 3'd4;

  // Board defaults at 50 MHz: 10 ms debounce, 0.5 s repeat delay, 0.25 s period.
  localparam int c_DEF_DEBOUNCE_CYCLES = 500000;
  localparam int c_DEF_REPEAT_DELAY    = 25000000;
  localparam int c_DEF_REPEAT_PERIOD   = 12500000;
  localparam int c_DEF_REPEAT_EN       = 1;
  localparam int c_DEF_CNT_W           = 25;

endpackage
`default_nettype wire

// File: rtl/key_step_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_step_conditioner_if                                      |
// | Description : Board-side bundle for the step conditioner.                  |
// |   master : drives KEY_N, SW_UP, SW_EN, SW_CLR; observes the outputs        |
// |   slave  : the conditioner; receives raw inputs, drives STEP, STEP_UP,     |
// |            STEP_EN, CLR, PRESSED                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface key_step_conditioner_if;
  logic KEY_N;
  logic SW_UP;
  logic SW_EN;
  logic SW_CLR;
  logic STEP;
  logic STEP_UP;
  logic STEP_EN;
  logic CLR;
  logic PRESSED;

  modport master (
    output KEY_N, SW_UP, SW_EN, SW_CLR,
    input  STEP, STEP_UP, STEP_EN, CLR, PRESSED
  );

  modport slave (
    input  KEY_N, SW_UP, SW_EN, SW_CLR,
    output STEP, STEP_UP, STEP_EN, CLR, PRESSED
  );
endinterface
`default_nettype wire

// File: rtl/key_step_conditioner_sync2_ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync2_ff                                                     |
// | Description : Two-flop synchronizer, parameterized width and reset value.  |
// |   clk   : sampling clock                                                   |
// |   rst_n : asynchronous active-low reset, loads RST_VAL into both stages    |
// |   i_d   : asynchronous input bus                                           |
// |   o_q   : second-stage synchronized output                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync2_ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_step_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_step_conditioner                                         |
// | Description : Synchronizes and debounces an active-low pushbutton and      |
// |               emits one-cycle STEP pulses with optional auto-repeat.       |
// |   CLOCK_50 : system clock                                                  |
// |   RST_N    : asynchronous active-low reset                                 |
// |   bus      : slave side of key_step_conditioner_if                         |
// |              in : KEY_N (0 = pressed), SW_UP, SW_EN, SW_CLR                |
// |              out: STEP, STEP_UP, STEP_EN (captured at STEP), CLR, PRESSED  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_step_conditioner
  import key_step_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = c_DEF_REPEAT_EN,
  parameter int CNT_W           = c_DEF_CNT_W
) (
  input wire logic               CLOCK_50,
  input wire logic               RST_N,
  key_step_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic             w_key_s;
  logic [2:0]       w_sw_s;
  logic             w_up_s;
  logic             w_en_s;
  logic             w_clr_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_evt;
  logic             w_evt_nxt;

  logic             w_step;
  logic             w_pressed;
  logic             r_step;
  logic             r_pressed;
  logic             r_step_up;
  logic             r_step_en;

  sync2_ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_key (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .i_d   (bus.KEY_N),
    .o_q   (w_key_s)
  );

  sync2_ff #(.WIDTH(3), .RST_VAL(3'b000)) u_sync_sw (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .i_d   ({bus.SW_CLR, bus.SW_EN, bus.SW_UP}),
    .o_q   (w_sw_s)
  );

  assign w_up_s  = w_sw_s[0];
  assign w_en_s  = w_sw_s[1];
  assign w_clr_s = w_sw_s[2];

  // State register; r_evt marks the cycle after a STEP-worthy transition.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

  // Next-state logic. Key level is checked before the terminal count so a
  // release/bounce on the terminal edge always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_nxt = PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_evt_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      HELD: begin
        if (w_key_s) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
        end else if (REPEAT_EN != 0) begin
          if (r_cnt == c_RD_LAST) begin
            w_state_nxt = REPEAT;
            w_cnt_nxt   = '0;
            w_evt_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
          end
        end
      end
      REPEAT: begin
        if (w_key_s) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_RP_LAST) begin
          w_cnt_nxt   = '0;
          w_evt_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      RELEASE_DB: begin
        // A re-press while debouncing the release restarts the repeat delay.
        if (!w_key_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    w_step    = r_evt;
    w_pressed = (r_state == HELD) || (r_state == REPEAT) || (r_state == RELEASE_DB);
  end

  // Registered outputs; qualifiers are captured on the same edge STEP rises.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_step    <= 1'b0;
      r_pressed <= 1'b0;
      r_step_up <= 1'b0;
      r_step_en <= 1'b0;
    end else begin
      r_step    <= w_step;
      r_pressed <= w_pressed;
      if (w_step) begin
        r_step_up <= w_up_s;
        r_step_en <= w_en_s;
      end
    end
  end

  assign bus.STEP    = r_step;
  assign bus.PRESSED = r_pressed;
  assign bus.STEP_UP = r_step_up;
  assign bus.STEP_EN = r_step_en;
  assign bus.CLR     = w_clr_s;

endmodule
`default_nettype wire

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
- Upstream conditioning stage for the 2-bit up/down counter on the DE2 board.
- Samples the raw active-low pushbutton and the direction/enable/clear switches on CLOCK_50, synchronizes and debounces them, and emits a clean one-cycle STEP pulse with auto-repeat while the key is held.
- The counter then advances on STEP instead of on a bouncing KEY edge.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronized key must stay stable to accept a press or release (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: held cycles after the first STEP before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 12500000: cycles between auto-repeat STEPs (0.25 s).
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives exactly one STEP per press.
- CNT_W, 25: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK_50, in, 1: system clock.
- RST_N, in, 1: asynchronous, active-low reset.
- KEY_N, in, 1: raw pushbutton, 0 = pressed, asynchronous.
- SW_UP, in, 1: direction switch, 1 = count up, asynchronous.
- SW_EN, in, 1: count-enable switch, asynchronous.
- SW_CLR, in, 1: clear switch, asynchronous.
- STEP, out, 1: one-cycle advance pulse.
- STEP_UP, out, 1: SW_UP value captured with the most recent STEP.
- STEP_EN, out, 1: SW_EN value captured with the most recent STEP.
- CLR, out, 1: synchronized SW_CLR level.
- PRESSED, out, 1: debounced key level, 1 = held.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately):
  - KEY_N synchronizer flops = 1; switch synchronizer flops = 0.
  - FSM = IDLE; counter = 0.
  - STEP, STEP_UP, STEP_EN, CLR, PRESSED = 0.
- Synchronization: every input passes through two flops. key_s, up_s, en_s and clr_s are the second-stage outputs.
- CLR = clr_s. Latency is 2 edges. CLR is not debounced and not gated by STEP.
- FSM states: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB.
  - IDLE: on key_s==0, go to PRESS_DB with cnt=0.
  - PRESS_DB:
    - key_s==1: return to IDLE (bounce rejected, no STEP).
    - Otherwise cnt++.
    - When cnt==DEBOUNCE_CYCLES-1: go to HELD, cnt=0, PRESSED=1, pulse STEP.
  - HELD:
    - key_s==1: go to RELEASE_DB with cnt=0.
    - Else if REPEAT_EN: cnt++.
    - When cnt==REPEAT_DELAY-1: go to REPEAT, cnt=0, pulse STEP.
  - REPEAT:
    - key_s==1: go to RELEASE_DB with cnt=0.
    - Else cnt++.
    - When cnt==REPEAT_PERIOD-1: cnt=0, pulse STEP, stay in REPEAT.
  - RELEASE_DB:
    - key_s==0: return to HELD with cnt=0 and no STEP. This restarts the repeat delay.
    - Otherwise cnt++.
    - When cnt==DEBOUNCE_CYCLES-1: go to IDLE, PRESSED=0.
- Latency: with KEY_N held low, STEP rises exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples KEY_N low.
- STEP timing:
  - Registered; high for exactly one cycle per event.
  - Never high on two consecutive cycles.
  - REPEAT_PERIOD>=2 is required.
- Qualifiers: STEP_UP and STEP_EN load up_s and en_s on the same edge STEP rises, and hold until the next STEP. Switch changes between STEPs do not affect them.
- Counter saturation: cnt never exceeds the active terminal value. No wrap inside a state.
- Simultaneous events:
  - A release seen on the same edge as a repeat terminal count takes the release path; no STEP is issued.
  - A bounce on the terminal debounce edge rejects the press.
- Reset mid-press: all outputs clear immediately. After RST_N rises, a still-held key is treated as a new press: full synchronization plus debounce, then one STEP.
- Release without a STEP: a key released during PRESS_DB never produces STEP.

Decomposition:
- Shared package holds:
  - FSM state encoding: 3-bit localparams IDLE=0, PRESS_DB=1, HELD=2, REPEAT=3, RELEASE_DB=4.
  - Default timing constants for the 50 MHz board clock.
- One sub-module: sync2_ff.
  - Parameterized-width two-flop synchronizer with asynchronous active-low reset and a parameterized reset value.
  - Instantiated once for KEY_N (reset value 1) and once for the three switches (reset value 0).

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1):
- Clean press: KEY_N low at edge 0, held 8 cycles, then released.
  - STEP high only at edge 7 (4+3).
  - PRESSED=1 from edge 7 until 4 cycles after key_s returns to 1.
- Bounce: KEY_N toggles low/high every 2 cycles for 20 cycles, then stays high.
  - STEP never asserts; PRESSED stays 0.
- Auto-repeat: KEY_N held low for 40 cycles.
  - First STEP at edge 7, second at edge 17, then every 3 edges (20, 23, ...).
  - No STEP after release.
- Qualifier capture: SW_UP=1 and SW_EN=1 at the first STEP, SW_UP changed to 0 mid-hold.
  - STEP_UP=1 until the next repeat STEP, then 0.
  - STEP_EN stays 1.
- Reset mid-operation: RST_N pulsed low during REPEAT.
  - STEP, PRESSED, STEP_UP, STEP_EN and CLR drop to 0 without waiting for a clock edge.
  - With the key still held, the next STEP comes 7 edges after RST_N rises.
- No repeat: REPEAT_EN=0, key held 40 cycles.
  - Exactly one STEP at edge 7.
  - SW_CLR=1 gives CLR=1 two edges later, independent of STEP.
